// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one external memory bus between instruction fetch (i_*) and the
//   load/store unit (d_*). The winning request is latched, driven on the bus
//   until mem_ready, and the response is routed back to its owner.
//   Arbitration is round-robin on the last granted port.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   i_valid/i_addr    fetch request; i_flush discards the in-flight fetch response
//   i_ready/i_rdata   fetch response
//   d_valid/d_addr/d_wdata/d_wstrb   load/store request (wstrb == 0 is a load)
//   d_ready/d_rdata   load/store response
//   mem_valid/mem_instr/mem_addr/mem_wdata/mem_wstrb   shared bus request
//   mem_ready/mem_rdata                                shared bus response
//   busy              a transaction is owned by one of the ports
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic                  i_flush,
    output logic                  i_ready,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_valid,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic                  d_ready,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  mem_valid,
    output logic                  mem_instr,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IBUS = 2'd1,
        DBUS = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_q,  last_d;   // 0 = fetch granted last, 1 = data
    logic                drop_q,  drop_d;   // swallow the current fetch response
    logic                instr_q, instr_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;

    logic completing;
    logic arb_en;
    logic cand_i, cand_d;
    logic grant_i, grant_d;

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        drop_d  = drop_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;

        completing = mem_ready && (state_q != IDLE);
        arb_en     = (state_q == IDLE) || completing;

        // The port finishing this cycle cannot win again immediately; its
        // valid is still high from the request just being served.
        cand_i = i_valid && (state_q != IBUS);
        cand_d = d_valid && (state_q != DBUS);

        // On a tie the port that did not win last time gets the bus.
        grant_d = cand_d && (!cand_i || !last_q);
        grant_i = cand_i && (!cand_d ||  last_q);

        // Completion clears drop even if a flush arrives in the same cycle,
        // since that transaction is over; i_ready is masked by i_flush directly.
        if (state_q == IBUS) begin
            if (mem_ready) begin
                drop_d = 1'b0;
            end else if (i_flush) begin
                drop_d = 1'b1;
            end
        end

        if (arb_en) begin
            state_d = IDLE;
            if (grant_d) begin
                state_d = DBUS;
                last_d  = 1'b1;
                instr_d = 1'b0;
                addr_d  = d_addr;
                wdata_d = d_wdata;
                wstrb_d = d_wstrb;
            end else if (grant_i) begin
                state_d = IBUS;
                last_d  = 1'b0;
                instr_d = 1'b1;
                addr_d  = i_addr;
                wdata_d = '0;
                wstrb_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b0;
            drop_q  <= 1'b0;
            instr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
        end
    end

    assign mem_valid = (state_q != IDLE);
    assign busy      = (state_q != IDLE);
    assign mem_instr = instr_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;

    assign d_ready = (state_q == DBUS) && mem_ready;
    assign i_ready = (state_q == IBUS) && mem_ready && !drop_q && !i_flush;
    assign i_rdata = mem_rdata;
    assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid, i_flush, d_valid, mem_ready;
    logic [AW-1:0] i_addr, d_addr;
    logic [DW-1:0] d_wdata, mem_rdata;
    logic [SW-1:0] d_wstrb;
    logic          i_ready, d_ready, mem_valid, mem_instr, busy;
    logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [SW-1:0] mem_wstrb;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_valid   (i_valid),
        .i_addr    (i_addr),
        .i_flush   (i_flush),
        .i_ready   (i_ready),
        .i_rdata   (i_rdata),
        .d_valid   (d_valid),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_wstrb   (d_wstrb),
        .d_ready   (d_ready),
        .d_rdata   (d_rdata),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst, iv, fl, dv, mr;
        logic [AW-1:0] ia, da;
        logic [DW-1:0] dw, mrd;
        logic [SW-1:0] ds;
        logic          e_mv, e_mi, e_ir, e_dr, e_busy;
        logic [AW-1:0] e_ma;
        logic [DW-1:0] e_mw;
        logic [SW-1:0] e_ms;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic add(input logic r, input logic iv, input logic [AW-1:0] ia, input logic fl,
                       input logic dv, input logic [AW-1:0] da, input logic [DW-1:0] dw,
                       input logic [SW-1:0] ds, input logic mr, input logic [DW-1:0] mrd,
                       input logic e_mv, input logic e_mi, input logic [AW-1:0] e_ma,
                       input logic [DW-1:0] e_mw, input logic [SW-1:0] e_ms,
                       input logic e_ir, input logic e_dr, input logic e_busy);
        vec_t v;
        v.rst = r;  v.iv = iv; v.ia = ia; v.fl = fl; v.dv = dv; v.da = da; v.dw = dw;
        v.ds = ds;  v.mr = mr; v.mrd = mrd;
        v.e_mv = e_mv; v.e_mi = e_mi; v.e_ma = e_ma; v.e_mw = e_mw; v.e_ms = e_ms;
        v.e_ir = e_ir; v.e_dr = e_dr; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    // Drive at the falling edge, check 1ns later, then let the rising edge act.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; i_valid = v.iv; i_addr = v.ia; i_flush = v.fl;
        d_valid = v.dv; d_addr = v.da; d_wdata = v.dw; d_wstrb = v.ds;
        mem_ready = v.mr; mem_rdata = v.mrd;
        #1;
        n_vec++;
        chk("mem_valid", idx, DW'(mem_valid), DW'(v.e_mv));
        chk("mem_instr", idx, DW'(mem_instr), DW'(v.e_mi));
        chk("mem_addr",  idx, DW'(mem_addr),  DW'(v.e_ma));
        chk("mem_wdata", idx, mem_wdata,      v.e_mw);
        chk("mem_wstrb", idx, DW'(mem_wstrb), DW'(v.e_ms));
        chk("i_ready",   idx, DW'(i_ready),   DW'(v.e_ir));
        chk("d_ready",   idx, DW'(d_ready),   DW'(v.e_dr));
        chk("busy",      idx, DW'(busy),      DW'(v.e_busy));
        chk("i_rdata",   idx, i_rdata,        v.mrd);
        chk("d_rdata",   idx, d_rdata,        v.mrd);
    endtask

    initial begin
        vec_t v;
        rst = 1'b1; i_valid = 1'b0; i_addr = '0; i_flush = 1'b0;
        d_valid = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_ready = 1'b0; mem_rdata = '0;

        //   rst iv ia      fl dv da      dw            ds    mr mrd       | mv mi ma      mw            ms    ir dr busy
        // Reset held with both requests pending, then data wins the first tie.
        add(1, 1, 'h40,   0, 1, 'h80,   'h0,          'h0,  0, 'h0,      0, 0, 'h0,    'h0,          'h0,  0, 0, 0);
        add(1, 1, 'h40,   0, 1, 'h80,   'h0,          'h0,  0, 'h0,      0, 0, 'h0,    'h0,          'h0,  0, 0, 0);
        add(0, 1, 'h40,   0, 1, 'h80,   'h0,          'h0,  0, 'h0,      0, 0, 'h0,    'h0,          'h0,  0, 0, 0);
        add(0, 1, 'h40,   0, 1, 'h80,   'h0,          'h0,  1, 'h11,     1, 0, 'h80,   'h0,          'h0,  0, 1, 1);
        add(0, 1, 'h40,   0, 0, 'h80,   'h0,          'h0,  1, 'h22,     1, 1, 'h40,   'h0,          'h0,  1, 0, 1);
        // mem_ready in IDLE is ignored
        add(0, 0, 'h40,   0, 0, 'h80,   'h0,          'h0,  1, 'h33,     0, 1, 'h40,   'h0,          'h0,  0, 0, 0);
        // Single fetch, three wait cycles
        add(0, 1, 'h100,  0, 0, 'h80,   'h0,          'h0,  0, 'h0,      0, 1, 'h40,   'h0,          'h0,  0, 0, 0);
        add(0, 1, 'h100,  0, 0, 'h80,   'h0,          'h0,  0, 'h0,      1, 1, 'h100,  'h0,          'h0,  0, 0, 1);
        add(0, 1, 'h100,  0, 0, 'h80,   'h0,          'h0,  0, 'h0,      1, 1, 'h100,  'h0,          'h0,  0, 0, 1);
        add(0, 1, 'h100,  0, 0, 'h80,   'h0,          'h0,  0, 'h0,      1, 1, 'h100,  'h0,          'h0,  0, 0, 1);
        add(0, 1, 'h100,  0, 0, 'h80,   'h0,          'h0,  1, 'h13,     1, 1, 'h100,  'h0,          'h0,  1, 0, 1);
        // Store
        add(0, 0, 'h100,  0, 1, 'h2004, 'hDEADBEEF,   'hF,  0, 'h0,      0, 1, 'h100,  'h0,          'h0,  0, 0, 0);
        add(0, 0, 'h100,  0, 1, 'h2004, 'hDEADBEEF,   'hF,  0, 'h0,      1, 0, 'h2004, 'hDEADBEEF,   'hF,  0, 0, 1);
        add(0, 0, 'h100,  0, 1, 'h2004, 'hDEADBEEF,   'hF,  1, 'h44,     1, 0, 'h2004, 'hDEADBEEF,   'hF,  0, 1, 1);
        // Flush one cycle into a three-wait fetch swallows its response
        add(0, 1, 'h180,  0, 0, 'h2004, 'hDEADBEEF,   'hF,  0, 'h0,      0, 0, 'h2004, 'hDEADBEEF,   'hF,  0, 0, 0);
        add(0, 1, 'h180,  1, 0, 'h2004, 'hDEADBEEF,   'hF,  0, 'h0,      1, 1, 'h180,  'h0,          'h0,  0, 0, 1);
        add(0, 1, 'h180,  0, 0, 'h2004, 'hDEADBEEF,   'hF,  0, 'h0,      1, 1, 'h180,  'h0,          'h0,  0, 0, 1);
        add(0, 1, 'h180,  0, 0, 'h2004, 'hDEADBEEF,   'hF,  0, 'h0,      1, 1, 'h180,  'h0,          'h0,  0, 0, 1);
        add(0, 1, 'h180,  0, 0, 'h2004, 'hDEADBEEF,   'hF,  1, 'h55,     1, 1, 'h180,  'h0,          'h0,  0, 0, 1);
        // New fetch after the flush is served normally
        add(0, 1, 'h200,  0, 0, 'h2004, 'hDEADBEEF,   'hF,  0, 'h0,      0, 1, 'h180,  'h0,          'h0,  0, 0, 0);
        add(0, 1, 'h200,  0, 0, 'h2004, 'hDEADBEEF,   'hF,  1, 'h77,     1, 1, 'h200,  'h0,          'h0,  1, 0, 1);
        // Flush in the completion cycle, then flush in IDLE has no effect
        add(0, 1, 'h204,  0, 0, 'h2004, 'hDEADBEEF,   'hF,  0, 'h0,      0, 1, 'h200,  'h0,          'h0,  0, 0, 0);
        add(0, 1, 'h204,  1, 0, 'h2004, 'hDEADBEEF,   'hF,  1, 'h88,     1, 1, 'h204,  'h0,          'h0,  0, 0, 1);
        add(0, 0, 'h204,  0, 0, 'h2004, 'hDEADBEEF,   'hF,  0, 'h0,      0, 1, 'h204,  'h0,          'h0,  0, 0, 0);
        add(0, 1, 'h208,  1, 0, 'h2004, 'hDEADBEEF,   'hF,  0, 'h0,      0, 1, 'h204,  'h0,          'h0,  0, 0, 0);
        add(0, 1, 'h208,  0, 0, 'h2004, 'hDEADBEEF,   'hF,  1, 'h99,     1, 1, 'h208,  'h0,          'h0,  1, 0, 1);

        foreach (vecs[k]) apply(vecs[k], k);

        // Contention with zero-wait memory: last grant was fetch, so D, I, D, I ...
        v = vecs[0];
        v.rst = 0; v.iv = 1; v.ia = 'h1000; v.fl = 0; v.dv = 1; v.da = 'h3000;
        v.dw = 'h12345678; v.ds = 'h3; v.mr = 1; v.mrd = 'hA5;
        v.e_mv = 0; v.e_mi = 1; v.e_ma = 'h208; v.e_mw = '0; v.e_ms = '0;
        v.e_ir = 0; v.e_dr = 0; v.e_busy = 0;
        apply(v, 100);
        for (int k = 1; k <= 6; k++) begin
            logic is_i;
            is_i = ((k % 2) == 0);
            v.mrd    = DW'(32'hA0 + k);
            v.e_mv   = 1; v.e_busy = 1;
            v.e_mi   = is_i;
            v.e_ma   = is_i ? AW'('h1000) : AW'('h3000);
            v.e_mw   = is_i ? '0 : DW'('h12345678);
            v.e_ms   = is_i ? '0 : SW'('h3);
            v.e_ir   = is_i;
            v.e_dr   = !is_i;
            apply(v, 100 + k);
        end

        // Reset in DBUS before mem_ready; the late mem_ready is ignored.
        // (The last contention grant went to data, so DBUS is current.)
        v.iv = 0; v.mr = 0; v.mrd = 'hB0;
        v.e_mi = 0; v.e_ma = 'h3000; v.e_mw = 'h12345678; v.e_ms = 'h3;
        v.e_ir = 0; v.e_dr = 0; v.e_mv = 1; v.e_busy = 1;
        apply(v, 200);
        v.rst = 1;
        apply(v, 201);
        v.rst = 0; v.dv = 0; v.mr = 1; v.mrd = 'hB1;
        v.e_mv = 0; v.e_busy = 0; v.e_ma = '0; v.e_mw = '0; v.e_ms = '0;
        apply(v, 202);
        apply(v, 203);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port to one-port memory arbiter that shares the single external memory bus between instruction fetch and the execute-stage load/store unit. It latches the winning request, drives the shared bus until the memory returns `mem_ready`, and routes the response back to the owning requester. Arbitration is round-robin, and a fetch flush can discard an in-flight fetch response. It sits between the fetch/execute stages and the memory/bus bridge; the execute stage still sees its usual `mem_ready` and `mem_rdata`.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; strobe width is `DATA_W/8`

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset; one clock; reset is synchronous and active-high
- `i_valid`  in  1  fetch request
- `i_addr`  in  ADDR_W  fetch address
- `i_flush`  in  1  discard the current or pending fetch response
- `i_ready`  out  1  fetch response valid
- `i_rdata`  out  DATA_W  fetch data
- `d_valid`  in  1  load/store request
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_wstrb`  in  DATA_W/8  byte strobes; all zeros means load
- `d_ready`  out  1  data response valid
- `d_rdata`  out  DATA_W  load data
- `mem_valid`  out  1  shared-bus request
- `mem_instr`  out  1  1 = fetch transaction
- `mem_addr`  out  ADDR_W  shared-bus address
- `mem_wdata`  out  DATA_W  shared-bus write data
- `mem_wstrb`  out  DATA_W/8  shared-bus strobes
- `mem_ready`  in  1  memory completion
- `mem_rdata`  in  DATA_W  memory read data
- `busy`  out  1  state is not IDLE

## Operation
- **States:** IDLE, IBUS, DBUS. One `last` bit records the last granted port: 0 = fetch, 1 = data.
- **Requester protocol:** a requester holds `*_valid` and its payload stable until its `*_ready` pulse. It drops or changes the request in the cycle after `*_ready`.
- **Arbitration:** evaluated in IDLE and in the completion cycle of IBUS/DBUS.
  - Candidates are the asserted valids, excluding the port completing in that cycle.
  - One candidate: that port wins.
  - Both candidates: the port not equal to `last` wins.
  - Winner d leads to DBUS; winner i leads to IBUS; no candidate leads to IDLE.
- **On grant:** the winner's addr/wdata/wstrb are latched into registers, plus `mem_instr` (1 for IBUS). Fetch grants latch `wstrb = 0`. `last` is updated.
- **IBUS/DBUS:** `mem_valid = 1` with the latched payload. The state is held until `mem_ready = 1`.
- **Completion, DBUS:** `d_ready = mem_ready`, `d_rdata = mem_rdata`, both combinational in the same cycle.
- **Completion, IBUS:** `i_ready = mem_ready & ~drop & ~i_flush`, `i_rdata = mem_rdata`.
- **drop flag:**
  - Set when `i_flush = 1` while in IBUS.
  - Cleared on IBUS completion.
  - While set, the fetch response is swallowed and the bus transaction finishes normally.
  - `i_flush` in IDLE or DBUS has no effect; a pending `i_valid` is simply re-evaluated.
- **Inactive outputs:** `*_ready` are 0 outside the owning state. `*_rdata` mirror `mem_rdata` at all times.
- **`mem_ready` in IDLE:** ignored; no ready is produced.

## Timing
- **Reset values:** state IDLE, `last = 0` (data wins the first tie), `drop = 0`. After reset: `mem_valid = 0`, `i_ready = 0`, `d_ready = 0`, `busy = 0`. Latched payload registers are 0, so `mem_addr`, `mem_wdata`, `mem_wstrb` and `mem_instr` read 0.
- **Latency:** request seen in IDLE at cycle N leads to `mem_valid` at N+1. With zero-wait memory (`mem_ready` high at N+1), `*_ready` is at N+1, so minimum latency is 1 cycle.
- **Back-to-back:** completion and the next grant happen in the same cycle, so there is no idle bubble between transactions.
- **Simultaneous events:**
  - Both requests in the same IDLE cycle: round-robin applies.
  - `i_flush` in the completion cycle: suppresses `i_ready` that cycle.
- **Reset mid-transaction:** the next cycle is IDLE with `mem_valid = 0`. Any `mem_ready` arriving afterwards is ignored.
- **Stall-free guarantee:** each port waits at most one foreign transaction before its grant.

## Test plan
- **Reset:** hold `rst = 1` for 2 cycles with `i_valid = d_valid = 1` -> `mem_valid`, `i_ready`, `d_ready` and `busy` all 0. Then release `rst` -> DBUS first; `mem_addr` = `d_addr`, `mem_instr = 0`.
- **Single fetch:** `i_addr = 0x100`, memory returns `0x00000013` after 3 wait cycles -> `mem_valid` high for 4 cycles, then a one-cycle `i_ready` with `i_rdata = 0x13`.
- **Contention:** both ports request continuously, zero-wait memory -> grants alternate D, I, D, I. `mem_instr` toggles every cycle with no bubbles.
- **Store:** `d_addr = 0x2004`, `d_wdata = 0xDEADBEEF`, `d_wstrb = 0xF` -> bus carries exactly that payload. `d_ready` is asserted on `mem_ready`; `i_ready` stays 0.
- **Flush:** pulse `i_flush` one cycle into a 3-wait-cycle fetch -> no `i_ready` for that transaction. A new `i_valid` with `i_addr = 0x200` is then served next, with its data returned.
- **Reset mid-transaction:** assert `rst` during DBUS before `mem_ready` -> IDLE next cycle. A late `mem_ready` does not assert `d_ready`.
